// File: rtl/msu_stream_pkg.sv
// Shared types for msu_stream: FSM states, status codes and frame-length helpers.
// Beat counts come from the parameter set so the top and the bench agree on framing.
package msu_stream_pkg;

  typedef enum logic [3:0] {
    ST_IDLE,
    ST_RECV,
    ST_DRAIN,
    ST_LOAD,
    ST_SQ_ISSUE,
    ST_SQ_WAIT,
    ST_PREP_SEND,
    ST_SEND,
    ST_DONE
  } state_e;

  localparam logic [1:0] STATUS_OK    = 2'd0;
  localparam logic [1:0] STATUS_SHORT = 2'd1;
  localparam logic [1:0] STATUS_LONG  = 2'd2;
  localparam logic [1:0] STATUS_ABORT = 2'd3;

  function automatic int in_beats(input int axi_len, input int t_len, input int sq_bits);
    return (2 * t_len + sq_bits) / axi_len;
  endfunction

  function automatic int out_beats(input int axi_len, input int t_len, input int sq_bits);
    return (t_len + sq_bits) / axi_len;
  endfunction

endpackage

// File: rtl/axis_shift_out.sv
// Output shift register: a loaded word leaves LSB-first, one AXI_LEN beat per accepted transfer.
// Data holds while tready_i is low; tlast_o flags the final beat, done_o pulses when it is taken.
module axis_shift_out #(
  parameter int W     = 32,
  parameter int BEATS = 6
) (
  input  logic             clk_i,
  input  logic             reset_i,
  input  logic             load_i,
  input  logic [W*BEATS-1:0] load_dat_i,
  input  logic             tready_i,
  output logic             tvalid_o,
  output logic [W-1:0]     tdata_o,
  output logic             tlast_o,
  output logic             done_o
);
  localparam int CNT_W = $clog2(BEATS + 1);

  logic [W*BEATS-1:0] sh_q, sh_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               vld_q, vld_d;
  logic               last;

  assign last     = vld_q && (cnt_q == CNT_W'(BEATS - 1));
  assign tvalid_o = vld_q;
  assign tdata_o  = sh_q[W-1:0];
  assign tlast_o  = last;
  assign done_o   = last && tready_i;

  always_comb begin
    sh_d  = sh_q;
    cnt_d = cnt_q;
    vld_d = vld_q;
    if (load_i) begin
      sh_d  = load_dat_i;
      cnt_d = '0;
      vld_d = 1'b1;
    end else if (vld_q && tready_i) begin
      sh_d  = sh_q >> W;
      cnt_d = cnt_q + CNT_W'(1);
      if (last) vld_d = 1'b0;
    end
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      sh_q  <= '0;
      cnt_q <= '0;
      vld_q <= 1'b0;
    end else begin
      sh_q  <= sh_d;
      cnt_q <= cnt_d;
      vld_q <= vld_d;
    end
  end

endmodule

// File: rtl/msu_stream.sv
// Streaming MSU controller: receive job frame, iterate the external squaring core (latency+1 per step), send result.
// Input is always ready in RECV/DRAIN; the output frame stalls indefinitely on m_axis_tready and is never aborted.
module msu_stream
  import msu_stream_pkg::*;
#(
  parameter int AXI_LEN           = 32,
  parameter int T_LEN             = 64,
  parameter int SQ_BITS           = 128,
  parameter int C_XFER_SIZE_WIDTH = 32
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         ap_start,
  input  logic                         abort,
  output logic                         ap_done,
  output logic [1:0]                   status,
  input  logic                         s_axis_tvalid,
  output logic                         s_axis_tready,
  input  logic [AXI_LEN-1:0]           s_axis_tdata,
  input  logic                         s_axis_tlast,
  output logic [C_XFER_SIZE_WIDTH-1:0] s_axis_xfer_size_in_bytes,
  output logic                         m_axis_tvalid,
  input  logic                         m_axis_tready,
  output logic [AXI_LEN-1:0]           m_axis_tdata,
  output logic [AXI_LEN/8-1:0]         m_axis_tkeep,
  output logic                         m_axis_tlast,
  output logic [C_XFER_SIZE_WIDTH-1:0] m_axis_xfer_size_in_bytes,
  output logic                         start_xfer,
  output logic                         sq_start,
  output logic [SQ_BITS-1:0]           sq_in,
  input  logic [SQ_BITS-1:0]           sq_out,
  input  logic                         sq_valid
);
  localparam int IN_BEATS  = in_beats(AXI_LEN, T_LEN, SQ_BITS);
  localparam int OUT_BEATS = out_beats(AXI_LEN, T_LEN, SQ_BITS);
  localparam int IN_W      = IN_BEATS * AXI_LEN;
  localparam int ICW       = $clog2(IN_BEATS + 1);

  state_e             state_q, state_d;
  logic [IN_W-1:0]    in_sr_q, in_sr_d;
  logic [ICW-1:0]     in_cnt_q, in_cnt_d;
  logic [T_LEN-1:0]   t_cur_q, t_cur_d, t_fin_q, t_fin_d, t_inc;
  logic [SQ_BITS-1:0] sq_val_q, sq_val_d;
  logic [1:0]         status_q, status_d;
  logic               in_acc, in_last_beat, bypass, load_out, out_done;

  assign in_acc       = s_axis_tvalid && s_axis_tready;
  assign in_last_beat = (in_cnt_q == ICW'(IN_BEATS - 1));
  // Frame fields are read straight from the shift register so LOAD can decide the bypass in the same cycle.
  assign bypass       = (in_sr_q[2*T_LEN-1:T_LEN] <= in_sr_q[T_LEN-1:0]);
  assign t_inc        = t_cur_q + T_LEN'(1);
  assign load_out     = (state_q == ST_PREP_SEND);

  assign status                    = status_q;
  assign sq_in                     = sq_val_q;
  assign m_axis_tkeep              = '1;
  assign s_axis_xfer_size_in_bytes = C_XFER_SIZE_WIDTH'(IN_BEATS * AXI_LEN / 8);
  assign m_axis_xfer_size_in_bytes = C_XFER_SIZE_WIDTH'(OUT_BEATS * AXI_LEN / 8);

  always_ff @(posedge clk) begin
    if (reset) state_q <= ST_IDLE;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:      if (ap_start) state_d = ST_RECV;
      ST_RECV: begin
        if (abort) state_d = ST_DONE;
        else if (in_acc) begin
          if (s_axis_tlast)      state_d = in_last_beat ? ST_LOAD : ST_DONE;
          else if (in_last_beat) state_d = ST_DRAIN;
        end
      end
      ST_DRAIN:     if (abort || (s_axis_tvalid && s_axis_tlast)) state_d = ST_DONE;
      ST_LOAD:      state_d = abort ? ST_DONE : (bypass ? ST_PREP_SEND : ST_SQ_ISSUE);
      ST_SQ_ISSUE:  state_d = abort ? ST_DONE : ST_SQ_WAIT;
      ST_SQ_WAIT: begin
        if (abort)         state_d = ST_DONE;
        else if (sq_valid) state_d = (t_inc == t_fin_q) ? ST_PREP_SEND : ST_SQ_ISSUE;
      end
      ST_PREP_SEND: state_d = ST_SEND;
      ST_SEND:      if (out_done) state_d = ST_DONE;
      ST_DONE:      state_d = ST_IDLE;
      default:      state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    s_axis_tready = 1'b0;
    sq_start      = 1'b0;
    start_xfer    = 1'b0;
    ap_done       = 1'b0;
    case (state_q)
      ST_RECV, ST_DRAIN: s_axis_tready = 1'b1;
      ST_SQ_ISSUE:       sq_start      = 1'b1;
      ST_PREP_SEND:      start_xfer    = 1'b1;
      ST_DONE:           ap_done       = 1'b1;
      default: ;
    endcase
  end

  always_comb begin
    in_sr_d  = in_sr_q;
    in_cnt_d = in_cnt_q;
    t_cur_d  = t_cur_q;
    t_fin_d  = t_fin_q;
    sq_val_d = sq_val_q;
    status_d = status_q;
    case (state_q)
      ST_IDLE: if (ap_start) begin
        in_cnt_d = '0;
        status_d = STATUS_OK;
      end
      ST_RECV: begin
        if (abort) status_d = STATUS_ABORT;
        else if (in_acc) begin
          in_sr_d  = {s_axis_tdata, in_sr_q[IN_W-1:AXI_LEN]};
          in_cnt_d = in_cnt_q + ICW'(1);
          if (s_axis_tlast && !in_last_beat)      status_d = STATUS_SHORT;
          else if (!s_axis_tlast && in_last_beat) status_d = STATUS_LONG;
        end
      end
      ST_DRAIN, ST_SQ_ISSUE: if (abort) status_d = STATUS_ABORT;
      ST_LOAD: begin
        if (abort) status_d = STATUS_ABORT;
        else begin
          t_cur_d  = in_sr_q[T_LEN-1:0];
          t_fin_d  = in_sr_q[2*T_LEN-1:T_LEN];
          sq_val_d = in_sr_q[IN_W-1:2*T_LEN];
        end
      end
      ST_SQ_WAIT: begin
        if (abort) status_d = STATUS_ABORT;
        else if (sq_valid) begin
          sq_val_d = sq_out;
          t_cur_d  = t_inc;
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      in_sr_q  <= '0;
      in_cnt_q <= '0;
      t_cur_q  <= '0;
      t_fin_q  <= '0;
      sq_val_q <= '0;
      status_q <= STATUS_OK;
    end else begin
      in_sr_q  <= in_sr_d;
      in_cnt_q <= in_cnt_d;
      t_cur_q  <= t_cur_d;
      t_fin_q  <= t_fin_d;
      sq_val_q <= sq_val_d;
      status_q <= status_d;
    end
  end

  axis_shift_out #(
    .W     (AXI_LEN),
    .BEATS (OUT_BEATS)
  ) u_shift_out (
    .clk_i      (clk),
    .reset_i    (reset),
    .load_i     (load_out),
    .load_dat_i ({sq_val_q, t_cur_q}),
    .tready_i   (m_axis_tready),
    .tvalid_o   (m_axis_tvalid),
    .tdata_o    (m_axis_tdata),
    .tlast_o    (m_axis_tlast),
    .done_o     (out_done)
  );

endmodule

// File: tb/tb_msu_stream.sv
// Bench for msu_stream: directed vector table, abort/reset sequences and randomized jobs vs a reference model.
module tb_msu_stream;
  logic         clk = 1'b0;
  logic         reset, ap_start, abort, ap_done;
  logic [1:0]   status;
  logic         s_axis_tvalid, s_axis_tready, s_axis_tlast;
  logic [31:0]  s_axis_tdata, s_xfer, m_xfer, m_axis_tdata;
  logic         m_axis_tvalid, m_axis_tready, m_axis_tlast;
  logic [3:0]   m_axis_tkeep;
  logic         start_xfer, sq_start, sq_valid;
  logic [127:0] sq_in, sq_out;

  msu_stream dut (
    .clk(clk), .reset(reset), .ap_start(ap_start), .abort(abort), .ap_done(ap_done), .status(status),
    .s_axis_tvalid(s_axis_tvalid), .s_axis_tready(s_axis_tready), .s_axis_tdata(s_axis_tdata),
    .s_axis_tlast(s_axis_tlast), .s_axis_xfer_size_in_bytes(s_xfer),
    .m_axis_tvalid(m_axis_tvalid), .m_axis_tready(m_axis_tready), .m_axis_tdata(m_axis_tdata),
    .m_axis_tkeep(m_axis_tkeep), .m_axis_tlast(m_axis_tlast), .m_axis_xfer_size_in_bytes(m_xfer),
    .start_xfer(start_xfer), .sq_start(sq_start), .sq_in(sq_in), .sq_out(sq_out), .sq_valid(sq_valid)
  );

  always #5 clk = ~clk;

  int nvec = 0, nmis = 0;
  int n_sq = 0, n_done = 0, n_xfer = 0, n_acc = 0;
  logic [1:0]  done_status;
  logic [32:0] out_q[$];
  int          rdy_mode = 0;
  logic        rdy_tog = 1'b0;
  logic        hold_pend = 1'b0;
  logic [32:0] hold_dat;
  int          core_cnt = 0;
  logic [127:0] core_op;

  task automatic check(input string name, input logic [191:0] act, input logic [191:0] exp);
    nvec++;
    if (act !== exp) begin
      nmis++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Squaring core model: result = operand^2 mod 2^128, valid 3 cycles after sq_start is seen.
  always begin
    @(posedge clk); #1;
    sq_valid = 1'b0;
    if (reset) core_cnt = 0;
    else begin
      if (core_cnt > 0) begin
        core_cnt--;
        if (core_cnt == 0) begin
          sq_out   = core_op * core_op;
          sq_valid = 1'b1;
        end
      end
      if (sq_start) begin
        core_op  = sq_in;
        core_cnt = 3;
      end
    end
  end

  always begin
    @(posedge clk); #1;
    rdy_tog = ~rdy_tog;
    case (rdy_mode)
      0:       m_axis_tready = 1'b1;
      1:       m_axis_tready = rdy_tog;
      2:       m_axis_tready = 1'b0;
      default: m_axis_tready = 1'($urandom_range(0, 1));
    endcase
  end

  always @(negedge clk) begin
    if (sq_start)   n_sq++;
    if (start_xfer) n_xfer++;
    if (ap_done) begin
      n_done++;
      done_status = status;
    end
    if (s_axis_tvalid && s_axis_tready) n_acc++;
    if (hold_pend && m_axis_tvalid) check("stall hold", {m_axis_tlast, m_axis_tdata}, hold_dat);
    hold_pend = m_axis_tvalid && !m_axis_tready;
    hold_dat  = {m_axis_tlast, m_axis_tdata};
    if (m_axis_tvalid && m_axis_tready) out_q.push_back({m_axis_tlast, m_axis_tdata});
  end

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic start_job();
    ap_start = 1'b1; tick(); ap_start = 1'b0;
  endtask

  task automatic send_frame(input logic [255:0] frame, input int nbeats, input int last_idx, input bit gaps);
    int g;
    for (int i = 0; i < nbeats; i++) begin
      if (gaps && $urandom_range(0, 3) == 0) begin
        s_axis_tvalid = 1'b0; tick();
      end
      s_axis_tvalid = 1'b1;
      s_axis_tdata  = (i < 8) ? frame[32*i +: 32] : $urandom;
      s_axis_tlast  = (i == last_idx);
      g = 0;
      while (!s_axis_tready && g < 50) begin tick(); g++; end
      if (g >= 50) begin check("tready timeout", 0, 1); break; end
      tick();
    end
    s_axis_tvalid = 1'b0;
    s_axis_tlast  = 1'b0;
  endtask

  task automatic wait_done(input int base_done, input string tag);
    int g = 0;
    while (n_done == base_done && g < 3000) begin tick(); g++; end
    check({tag, " done seen"}, 192'(n_done - base_done), 1);
  endtask

  task automatic check_result(input string tag, input int b_sq, input int b_done, input int b_xfer,
                              input int b_acc, input int nbeats, input logic [1:0] exp_status, input int exp_nsq,
                              input logic [63:0] exp_t, input logic [127:0] exp_sq, input bit exp_frame);
    logic [191:0] ew;
    logic [32:0]  b;
    wait_done(b_done, tag);
    tick(); tick();
    check({tag, " ap_done pulses"}, 192'(n_done - b_done), 1);
    check({tag, " status"}, done_status, exp_status);
    check({tag, " status held"}, status, exp_status);
    check({tag, " sq_start count"}, 192'(n_sq - b_sq), 192'(exp_nsq));
    check({tag, " beats accepted"}, 192'(n_acc - b_acc), 192'(nbeats));
    check({tag, " start_xfer count"}, 192'(n_xfer - b_xfer), 192'(exp_frame));
    check({tag, " out beats"}, 192'(out_q.size()), exp_frame ? 6 : 0);
    ew = {exp_sq, exp_t};
    for (int i = 0; i < out_q.size() && i < 6; i++) begin
      b = out_q[i];
      check($sformatf("%s beat%0d data", tag, i), b[31:0], ew[32*i +: 32]);
      check($sformatf("%s beat%0d tlast", tag, i), b[32], (i == 5));
    end
  endtask

  task automatic run_job(input string tag, input logic [63:0] ts, input logic [63:0] tf, input logic [127:0] s0,
                         input int nbeats, input int last_idx, input int rmode, input bit gaps,
                         input logic [1:0] exp_status, input int exp_nsq, input logic [63:0] exp_t,
                         input logic [127:0] exp_sq, input bit exp_frame);
    int b_sq = n_sq, b_done = n_done, b_xfer = n_xfer, b_acc = n_acc;
    out_q.delete();
    rdy_mode = rmode;
    start_job();
    send_frame({s0, tf, ts}, nbeats, last_idx, gaps);
    check_result(tag, b_sq, b_done, b_xfer, b_acc, nbeats, exp_status, exp_nsq, exp_t, exp_sq, exp_frame);
    rdy_mode = 0;
  endtask

  // Reference: iterate squaring from t_start up to t_final; nothing to do when t_final <= t_start.
  task automatic ref_model(input logic [63:0] ts, input logic [63:0] tf, input logic [127:0] s0,
                           output logic [63:0] t_o, output logic [127:0] s_o, output int n);
    n   = (tf > ts) ? int'(tf - ts) : 0;
    s_o = s0;
    for (int i = 0; i < n; i++) s_o = s_o * s_o;
    t_o = (n == 0) ? ts : tf;
  endtask

  typedef struct {
    string        tag;
    logic [63:0]  ts, tf;
    logic [127:0] s0;
    int           nbeats, last_idx, rmode;
    logic [1:0]   exp_status;
    int           exp_nsq;
    logic [63:0]  exp_t;
    logic [127:0] exp_sq;
    bit           exp_frame;
  } vec_t;

  vec_t vecs[8];

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [63:0]  ts, tf, et;
    logic [127:0] s0, es;
    int           n, b_sq, b_done, b_xfer, b_acc, g, delta, kind;

    vecs[0] = '{"nominal",   64'd0, 64'd3, 128'd3, 8, 7, 0, 2'd0, 3, 64'd3, 128'd6561, 1'b1};
    vecs[1] = '{"bypass",    64'd5, 64'd5, 128'h1234, 8, 7, 0, 2'd0, 0, 64'd5, 128'h1234, 1'b1};
    vecs[2] = '{"short",     64'd0, 64'd3, 128'd3, 5, 4, 0, 2'd1, 0, 64'd0, 128'd0, 1'b0};
    vecs[3] = '{"long",      64'd0, 64'd3, 128'd3, 10, 9, 0, 2'd2, 0, 64'd0, 128'd0, 1'b0};
    vecs[4] = '{"backpress", 64'd0, 64'd3, 128'd3, 8, 7, 1, 2'd0, 3, 64'd3, 128'd6561, 1'b1};
    vecs[5] = '{"wrapbyp",   64'hFFFF_FFFF_FFFF_FFFF, 64'd2, 128'h55, 8, 7, 0, 2'd0, 0,
                64'hFFFF_FFFF_FFFF_FFFF, 128'h55, 1'b1};
    vecs[6] = '{"backward",  64'd10, 64'd4, 128'h77, 8, 7, 0, 2'd0, 0, 64'd10, 128'h77, 1'b1};
    vecs[7] = '{"trunc",     64'hFFFF_FFFF_FFFF_FFFE, 64'hFFFF_FFFF_FFFF_FFFF, 128'h1_0000_0000_0000_0001,
                8, 7, 3, 2'd0, 1, 64'hFFFF_FFFF_FFFF_FFFF, 128'h2_0000_0000_0000_0001, 1'b1};

    reset = 1'b1; ap_start = 1'b0; abort = 1'b0;
    s_axis_tvalid = 1'b0; s_axis_tdata = '0; s_axis_tlast = 1'b0;
    m_axis_tready = 1'b0; sq_valid = 1'b0; sq_out = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst ap_done", ap_done, 0);
    check("rst start_xfer", start_xfer, 0);
    check("rst sq_start", sq_start, 0);
    check("rst s_tready", s_axis_tready, 0);
    check("rst m_tvalid", m_axis_tvalid, 0);
    check("rst m_tlast", m_axis_tlast, 0);
    check("rst status", status, 0);
    check("in xfer size", s_xfer, 32);
    check("out xfer size", m_xfer, 24);
    check("tkeep", m_axis_tkeep, 4'hF);
    tick();
    reset = 1'b0;
    tick();

    foreach (vecs[k])
      run_job(vecs[k].tag, vecs[k].ts, vecs[k].tf, vecs[k].s0, vecs[k].nbeats, vecs[k].last_idx,
              vecs[k].rmode, 1'b0, vecs[k].exp_status, vecs[k].exp_nsq, vecs[k].exp_t, vecs[k].exp_sq,
              vecs[k].exp_frame);

    // Abort during the second squaring wait.
    b_sq = n_sq; b_done = n_done; b_xfer = n_xfer; b_acc = n_acc;
    out_q.delete();
    start_job();
    send_frame({128'd3, 64'd3, 64'd0}, 8, 7, 1'b0);
    g = 0;
    while (n_sq - b_sq < 2 && g < 200) begin tick(); g++; end
    abort = 1'b1; tick(); abort = 1'b0;
    check_result("abort", b_sq, b_done, b_xfer, b_acc, 8, 2'd3, 2, 64'd0, 128'd0, 1'b0);
    repeat (6) tick();
    check("abort late sq_valid ignored", 192'(out_q.size()), 0);

    // Reset while the output frame is stalled.
    rdy_mode = 2;
    start_job();
    send_frame({128'd3, 64'd3, 64'd0}, 8, 7, 1'b0);
    g = 0;
    while (!m_axis_tvalid && g < 200) begin tick(); g++; end
    check("rst_send reached SEND", m_axis_tvalid, 1);
    reset = 1'b1;
    @(posedge clk);
    @(negedge clk);
    check("rst_send tvalid", m_axis_tvalid, 0);
    check("rst_send tlast", m_axis_tlast, 0);
    check("rst_send status", status, 0);
    tick();
    reset = 1'b0; rdy_mode = 0;
    repeat (5) tick();
    run_job("after_reset", 64'd0, 64'd3, 128'd3, 8, 7, 0, 1'b0, 2'd0, 3, 64'd3, 128'd6561, 1'b1);

    for (int r = 0; r < 24; r++) begin
      ts = ($urandom_range(0, 3) == 0) ? 64'hFFFF_FFFF_FFFF_FFF8 + 64'($urandom_range(0, 7))
                                       : {$urandom, $urandom};
      delta = $urandom_range(0, 7) - 2;
      tf = ts + 64'(delta);
      s0 = {$urandom, $urandom, $urandom, $urandom};
      kind = $urandom_range(0, 5);
      if (kind == 0) begin
        n = $urandom_range(0, 6);
        run_job($sformatf("rnd%0d short", r), ts, tf, s0, n + 1, n, 0, 1'b1, 2'd1, 0, 64'd0, 128'd0, 1'b0);
      end else begin
        ref_model(ts, tf, s0, et, es, n);
        run_job($sformatf("rnd%0d", r), ts, tf, s0, 8, 7, (kind == 1) ? 1 : ((kind == 2) ? 3 : 0), 1'b1,
                2'd0, n, et, es, 1'b1);
      end
    end

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nmis);
    $finish;
  end

endmodule
